sprite_blitter: RTL
===================

# sprite_blitter

Sequencer for the CHIP-8/SCHIP/XO-CHIP draw instruction (DXYN). It reads sprite bytes from program RAM, does a read-XOR-write on each affected VRAM pixel, and reports collision. It sits between the CPU and the shared RAM/VRAM ports: the CPU hands it a latched draw command, muxes the RAM and VRAM ports to it while `busy`, and writes `collision` to VF on `done`.

## Interface
Parameters:
- `CLIP`, 1: 1 = pixels past the right/bottom edge are skipped; 0 = they wrap.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  draw request, sampled only in IDLE
- `x`, `y`  in  8 each  sprite origin (VX, VY)
- `n`  in  4  row count; 0 = 16x16 sprite
- `i_addr`  in  16  sprite base address (I)
- `planes`  in  2  plane mask (bit0 = plane 0, bit1 = plane 1)
- `hires`  in  1  1 = 128x64, 0 = 64x32
- `busy`  out  1  draw in progress
- `done`  out  1  one-cycle completion pulse
- `collision`  out  1  VF result; valid from `done`, held until the next accepted `start`
- `mem_addr`  out  16  RAM read address
- `mem_rdata`  in  8  RAM data, 1-cycle read latency
- `vram_hpos`  out  7  VRAM column
- `vram_vpos`  out  6  VRAM row
- `vram_pixelo`  in  2  VRAM read data, 1-cycle latency
- `vram_pixeli`  out  2  VRAM write data
- `vram_we`  out  1  VRAM write strobe

## Operation
- **Command capture:** `x`, `y`, `n`, `i_addr`, `planes` and `hires` are captured on the cycle `start` is accepted. `start` while `busy` is ignored.
- **Screen size:** W_S = 128/64 (hires/lores); H_S = 64/32. Lores coordinates address VRAM directly, with no scaling.
- **Origin:** x0 = x mod W_S, y0 = y mod H_S. The origin always wraps.
- **Geometry:**
  - n=0: 16 rows x 16 px, 2 bytes per row.
  - Otherwise: n rows x 8 px, 1 byte per row.
  - Bytes per plane B_P = rows x bytes-per-row.
- **Plane order:** plane 0 first (if selected), then plane 1. Each selected plane consumes B_P consecutive bytes starting at the running address, which starts at `i_addr`. The address is a 16-bit counter that wraps at 0xFFFF.
- **Row order:** rows top to bottom; bits MSB first, left to right.
- **Pixel at (x0+c, y0+r):**
  - Zero bit: no VRAM access.
  - Set bit off-screen with CLIP=1: skipped.
  - Set bit off-screen with CLIP=0: coordinates taken mod W_S / H_S.
  - Set visible bit: read `vram_pixelo`, write `vram_pixeli` = `vram_pixelo` XOR plane_bit, where plane_bit is one-hot for the current plane.
  - Collision is set if the prior value of the current plane bit was 1.
- **Empty plane mask:** `planes`=0 performs no fetch and no write; `done` is raised with `collision`=0.
- **FSM states:**
  - IDLE: `start` → FETCH, or → FINISH if `planes`=0.
  - FETCH: drive `mem_addr`.
  - LATCH: capture `mem_rdata` into the shift register.
  - SCAN: one cycle per bit. A set visible bit drives `vram_hpos`/`vram_vpos` and → RMW; otherwise advance.
  - RMW: `vram_we`=1 and update collision.
  - After the last bit of a byte → FETCH for the next byte, or → FINISH after the last byte of the last plane.
  - FINISH: `done`=1 → IDLE.

## Timing
- **Reset values:** `busy`=0, `done`=0, `collision`=0, `vram_we`=0, `mem_addr`=0, `vram_hpos`=0, `vram_vpos`=0, `vram_pixeli`=0.
- **busy:** high from the cycle after `start` is accepted through the FINISH cycle inclusive.
- **Latency:** `done` asserts exactly 2·B + 8·B + S + 1 cycles after the start cycle.
  - B = total bytes fetched; S = visible set bits (CLIP=1) or all set bits (CLIP=0).
  - `planes`=0: `done` asserts 1 cycle after start.
- **Write strobe:** `vram_we` is high only in RMW, for one cycle per pixel. Address is held from SCAN through RMW.
- **Reset mid-draw:** state asynchronously → IDLE and `vram_we` drops immediately. No `done` pulse; partial writes stand.

## Structure
- **Package `ghostchip_pkg`:**
  - FSM state enum.
  - `HRES_W`/`HRES_H` = 128/64 and `LRES_W`/`LRES_H` = 64/32.
  - `SPRITE_BIG_ROWS` = 16.
- **Sub-module `blit_clip`:** combinational. Takes (x0, c, y0, r, hires, CLIP) and produces the VRAM coordinates plus a `visible` flag.

## Test plan
- **Single pixel:** lores, x=0, y=0, n=1, I=0x200, RAM[0x200]=0x80, `planes`=01, VRAM clear → one write (0,0) with `vram_pixeli`=01, `collision`=0, `done` at cycle 12.
- **Erase:** repeat the same draw → (0,0) returns to 00, `collision`=1.
- **Right-edge clip:** lores, x=62, RAM byte 0xFF, CLIP=1 → writes only (62,0) and (63,0), `done` at cycle 13. With CLIP=0 → 8 writes, columns 62, 63, 0–5.
- **Origin wrap:** lores, x=70, y=33 → first pixel lands at (6,1).
- **Two-plane large sprite:** hires, n=0, `planes`=11 → 64 reads from I..I+63; plane 1 data from I+32; writes XOR bit 1.
- **Reset mid-draw:** assert `reset` low mid-draw → `busy`=0, `vram_we`=0, no `done`. A new `start` afterwards completes normally.

Source files
------------

// File: rtl/ghostchip_pkg.sv
// Shared types and screen constants for the DXYN sprite blitter.
package ghostchip_pkg;

  localparam int HRES_W          = 128;
  localparam int HRES_H          = 64;
  localparam int LRES_W          = 64;
  localparam int LRES_H          = 32;
  localparam int SPRITE_BIG_ROWS = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_SCAN,
    ST_RMW,
    ST_FINISH
  } blit_state_e;

  // Draw command as held for the duration of one blit.
  typedef struct packed {
    logic [6:0] x0;
    logic [5:0] y0;
    logic [3:0] rows_m1;
    logic       big;
    logic       p1;
    logic       hires;
  } blit_cmd_t;

endpackage

// File: rtl/blit_clip.sv
// Maps a sprite-relative pixel to VRAM coordinates, wrapping or flagging it off-screen.
module blit_clip
  import ghostchip_pkg::*;
#(
  parameter bit CLIP = 1'b1
) (
  input  logic [6:0] x0,
  input  logic [3:0] c,
  input  logic [5:0] y0,
  input  logic [3:0] r,
  input  logic       hires,
  output logic [6:0] hpos,
  output logic [5:0] vpos,
  output logic       visible
);

  logic [7:0] sx, sx_w, w;
  logic [6:0] sy, sy_w, h;
  logic       off_x, off_y;

  // Origin is already reduced, so one subtraction is enough to wrap.
  always_comb begin
    sx    = {1'b0, x0} + {4'd0, c};
    sy    = {1'b0, y0} + {3'd0, r};
    w     = hires ? 8'(HRES_W) : 8'(LRES_W);
    h     = hires ? 7'(HRES_H) : 7'(LRES_H);
    off_x = sx >= w;
    off_y = sy >= h;
    sx_w  = off_x ? sx - w : sx;
    sy_w  = off_y ? sy - h : sy;
  end

  assign hpos    = sx_w[6:0];
  assign vpos    = sy_w[5:0];
  assign visible = !CLIP || !(off_x || off_y);

  logic unused;
  assign unused = sx_w[7] ^ sy_w[6];

endmodule

// File: rtl/sprite_blitter.sv
// DXYN draw sequencer: fetches sprite bytes, XORs set pixels into VRAM, reports collision.
module sprite_blitter
  import ghostchip_pkg::*;
#(
  parameter bit CLIP = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  input  logic [3:0]  n,
  input  logic [15:0] i_addr,
  input  logic [1:0]  planes,
  input  logic        hires,
  output logic        busy,
  output logic        done,
  output logic        collision,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic [6:0]  vram_hpos,
  output logic [5:0]  vram_vpos,
  input  logic [1:0]  vram_pixelo,
  output logic [1:0]  vram_pixeli,
  output logic        vram_we
);

  blit_state_e state, state_nx;
  blit_cmd_t   cmd;
  logic        plane, half;
  logic [3:0]  row;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic [15:0] addr;
  logic [1:0]  plane_bit;
  logic [6:0]  clip_h;
  logic [5:0]  clip_v;
  logic        visible, hit, adv;
  logic        last_bit, row_end, plane_end, draw_end;

  blit_clip #(.CLIP(CLIP)) u_clip (
    .x0      (cmd.x0),
    .c       ({half, bit_idx}),
    .y0      (cmd.y0),
    .r       (row),
    .hires   (cmd.hires),
    .hpos    (clip_h),
    .vpos    (clip_v),
    .visible (visible)
  );

  assign plane_bit = plane ? 2'b10 : 2'b01;
  assign hit       = shreg[7] && visible;
  assign adv       = (state == ST_SCAN && !hit) || state == ST_RMW;
  assign last_bit  = bit_idx == 3'd7;
  assign row_end   = last_bit && (half || !cmd.big);
  assign plane_end = row_end && row == cmd.rows_m1;
  assign draw_end  = plane_end && (plane || !cmd.p1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    busy        = state != ST_IDLE;
    done        = state == ST_FINISH;
    vram_we     = state == ST_RMW;
    vram_hpos   = '0;
    vram_vpos   = '0;
    vram_pixeli = '0;
    case (state)
      ST_IDLE:  if (start) state_nx = (planes == 2'b00) ? ST_FINISH : ST_FETCH;
      ST_FETCH: state_nx = ST_LATCH;
      ST_LATCH: state_nx = ST_SCAN;
      ST_SCAN, ST_RMW: begin
        vram_hpos = clip_h;
        vram_vpos = clip_v;
        if (state == ST_RMW) vram_pixeli = vram_pixelo ^ plane_bit;
        if (state == ST_SCAN && hit) state_nx = ST_RMW;
        else if (last_bit)           state_nx = draw_end ? ST_FINISH : ST_FETCH;
        else                         state_nx = ST_SCAN;
      end
      ST_FINISH: state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // n-1 wraps to 15 for n=0, which is exactly the 16-row large sprite.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd       <= '0;
      plane     <= 1'b0;
      half      <= 1'b0;
      row       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      addr      <= '0;
      collision <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          cmd.x0      <= hires ? x[6:0] : {1'b0, x[5:0]};
          cmd.y0      <= hires ? y[5:0] : {1'b0, y[4:0]};
          cmd.rows_m1 <= n - 4'd1;
          cmd.big     <= n == 4'd0;
          cmd.p1      <= planes[1];
          cmd.hires   <= hires;
          plane       <= !planes[0];
          half        <= 1'b0;
          row         <= '0;
          bit_idx     <= '0;
          addr        <= i_addr;
          collision   <= 1'b0;
        end
        ST_LATCH: begin
          shreg <= mem_rdata;
          addr  <= addr + 16'd1;
        end
        ST_RMW: if (|(vram_pixelo & plane_bit)) collision <= 1'b1;
        default: ;
      endcase
      if (adv) begin
        bit_idx <= bit_idx + 3'd1;
        shreg   <= shreg << 1;
        if (last_bit) begin
          if (!row_end) half <= 1'b1;
          else begin
            half <= 1'b0;
            if (plane_end) begin
              row   <= '0;
              plane <= 1'b1;
            end else begin
              row <= row + 4'd1;
            end
          end
        end
      end
    end
  end

  assign mem_addr = addr;

  logic unused;
  assign unused = x[7] ^ y[7] ^ y[6];

endmodule
